// File: rtl/max_ctrl_pkg.sv
// Shared constants and state type for the argmax sequencer.
package max_ctrl_pkg;

    localparam int NUM_CLS = 9;
    localparam int LOGIT_W = 8;
    localparam int IDX_W   = 4;
    localparam int FRAME_W = NUM_CLS * LOGIT_W;

    localparam logic [LOGIT_W-1:0] PAD_DEFAULT = 8'h80;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        ISSUE   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/inf_res_fifo.sv
// Result FIFO for tagged argmax results; head is read straight from storage (no read latency).
// Push and pop may coincide at any occupancy; a push into a full FIFO without a pop is ignored.
module inf_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/max_unit_ctrl.sv
// Packs logit bytes into 9-logit frames, issues them to the argmax pipeline only when a result slot is reserved,
// and queues tagged results for a valid/ready consumer; issue is one cycle after frame close when credit allows.
module max_unit_ctrl
    import max_ctrl_pkg::*;
#(
    parameter int                 DEPTH   = 4,
    parameter int                 TAG_W   = 4,
    parameter logic [LOGIT_W-1:0] PAD_VAL = PAD_DEFAULT,
    parameter int                 MU_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LOGIT_W-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [FRAME_W-1:0] mu_data,
    output logic               mu_valid,
    input  logic [IDX_W-1:0]   mu_res,
    input  logic               mu_res_valid,
    output logic [IDX_W-1:0]   m_class,
    output logic [TAG_W-1:0]   m_tag,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               err_len,
    output logic               err_ovf,
    input  logic               clr_err,
    output logic               busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    ctrl_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_len_q, err_len_d;
    logic               err_ovf_q, err_ovf_d;

    logic [CW-1:0]          fifo_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TAG_W+IDX_W-1:0] fifo_head;

    logic s_acc;
    logic issue_ok;
    logic res_ok;
    logic fifo_pop;
    logic push_drop;
    logic fifo_wr;
    logic len_evt;
    logic ovf_evt;

    assign s_ready  = (state_q != ISSUE);
    assign s_acc    = s_valid & s_ready;
    // Credit: every issued frame must already own a FIFO slot, since the pipeline cannot stall.
    assign issue_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);
    assign mu_valid = (state_q == ISSUE) & issue_ok;
    assign mu_data  = frame_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        len_evt = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (s_acc) begin
                    for (int k = 0; k < NUM_CLS; k++) begin
                        if (4'(k) == cnt_q) begin
                            frame_d[k*LOGIT_W +: LOGIT_W] = s_data;
                        end else if (s_last && (4'(k) > cnt_q)) begin
                            frame_d[k*LOGIT_W +: LOGIT_W] = PAD_VAL;
                        end
                    end
                    if (s_last) begin
                        state_d = ISSUE;
                        cnt_d   = '0;
                    end else if (cnt_q == 4'(NUM_CLS - 1)) begin
                        state_d = DISCARD;
                        cnt_d   = '0;
                        len_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DISCARD: begin
                if (s_acc && s_last) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ok) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign res_ok     = mu_res_valid & (inflight_q != '0);
    assign m_valid    = ~fifo_empty;
    assign fifo_pop   = m_valid & m_ready;
    assign push_drop  = res_ok & fifo_full & ~fifo_pop;
    assign fifo_wr    = res_ok & ~push_drop;
    assign ovf_evt    = (mu_res_valid & (inflight_q == '0)) | push_drop;

    assign inflight_d = inflight_q + CW'(mu_valid) - CW'(res_ok);
    assign tag_d      = tag_q + TAG_W'(fifo_wr);
    // A new error in the clearing cycle wins over clr_err.
    assign err_len_d  = len_evt | (err_len_q & ~clr_err);
    assign err_ovf_d  = ovf_evt | (err_ovf_q & ~clr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            frame_q    <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            err_len_q  <= err_len_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    inf_res_fifo #(
        .WIDTH (TAG_W + IDX_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (res_ok),
        .data_i  ({tag_q, mu_res}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_class = fifo_head[IDX_W-1:0];
    assign m_tag   = fifo_head[IDX_W +: TAG_W];
    assign err_len = err_len_q;
    assign err_ovf = err_ovf_q;
    assign busy    = (state_q != COLLECT) | (cnt_q != '0) | (inflight_q != '0) | m_valid;

    // Results return MU_LAT cycles after issue, so in-flight frames are bounded by both depths.
    localparam int INFL_MAX = (DEPTH < MU_LAT) ? DEPTH : MU_LAT;
    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(inflight_q) <= INFL_MAX);
        end
    end

endmodule
